// File: rtl/lot_monitor.sv
// lot_monitor: parking-lot occupancy tracker.
// Each gate lane watches an outer (a) and an inner (b) sensor. A lane
// recognises a complete car traversal in either direction and emits a
// one-cycle enter/exit pulse. A shared saturating counter nets all lane
// pulses each cycle. A sticky error flag records any overflow or underflow.
module lot_monitor #(
  parameter int LANES    = 2,
  parameter int CAPACITY = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [2*LANES-1:0]                 ab,
  output logic [LANES-1:0]                   enter,
  output logic [LANES-1:0]                   exit,
  output logic [$clog2(CAPACITY+1)-1:0]      count,
  output logic                               full,
  output logic                               empty,
  output logic                               err
);

  localparam int CW = $clog2(CAPACITY + 1);
  // Signed working width: holds count plus or minus up to 8 pulses with headroom.
  localparam int SW = CW + 5;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  typedef enum logic [3:0] {
    IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, PED1, PED2
  } lane_state_e;

  // Lane transition rule. The pair is {a, b}, and 00 always means the gate is clear.
  function automatic lane_state_e next_state(lane_state_e s, logic [1:0] p);
    lane_state_e ns;
    ns = IDLE;
    if (p != 2'b00) begin
      unique case (s)
        IDLE:       ns = (p == 2'b10) ? IN1  : (p == 2'b01) ? OUT1 : PED1;
        IN1:        ns = (p == 2'b10) ? IN1  : (p == 2'b01) ? OUT1 : IN2;
        IN2, IN3:   ns = (p == 2'b10) ? IN1  : (p == 2'b11) ? IN2  : IN3;
        OUT1:       ns = (p == 2'b01) ? OUT1 : (p == 2'b10) ? IN1  : OUT2;
        OUT2, OUT3: ns = (p == 2'b01) ? OUT1 : (p == 2'b11) ? OUT2 : OUT3;
        PED1, PED2: ns = (p == 2'b11) ? PED1 : PED2;
        default:    ns = IDLE;
      endcase
    end
    return ns;
  endfunction

  lane_state_e     state_q [LANES];
  logic [LANES-1:0] enter_q;
  logic [LANES-1:0] exit_q;

  // Per-lane traversal FSMs with registered enter/exit pulses.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every lane decision uses pre-edge state.
    if (reset) begin
      for (int i = 0; i < LANES; i++) state_q[i] <= IDLE;
      enter_q <= '0;
      exit_q  <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        // The car has fully passed once the inner sensor clears from IN3.
        // The same applies to the outer sensor from OUT3.
        enter_q[i] <= (state_q[i] == IN3)  &&
                      (ab[2*i +: 2] == 2'b00 || ab[2*i +: 2] == 2'b10);
        exit_q[i]  <= (state_q[i] == OUT3) &&
                      (ab[2*i +: 2] == 2'b00 || ab[2*i +: 2] == 2'b01);
        state_q[i] <= next_state(state_q[i], ab[2*i +: 2]);
      end
    end
  end

  logic [CW-1:0]        count_q, count_d;
  logic                 err_q, err_d;
  logic [3:0]           e_cnt, x_cnt;
  logic signed [SW-1:0] sum;

  // Net all registered pulses, then clamp to 0..CAPACITY and flag any overflow or underflow.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    e_cnt   = '0;
    x_cnt   = '0;
    count_d = count_q;
    err_d   = err_q;
    for (int i = 0; i < LANES; i++) begin
      e_cnt = e_cnt + 4'(enter_q[i]);
      x_cnt = x_cnt + 4'(exit_q[i]);
    end
    sum = SW'(count_q) + SW'(e_cnt) - SW'(x_cnt);
    if (sum[SW-1]) begin
      count_d = '0;
      err_d   = 1'b1;
    end else if (sum > CAP_S) begin
      count_d = CW'(CAPACITY);
      err_d   = 1'b1;
    end else begin
      count_d = sum[CW-1:0];
    end
  end

  // Occupancy and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign enter = enter_q;
  assign exit  = exit_q;
  assign count = count_q;
  assign err   = err_q;
  assign full  = (count_q == CW'(CAPACITY));
  assign empty = (count_q == '0);

endmodule
